// File: rtl/full_subtractor_behav.sv
// Full subtractor: a - b - borrow_in as a ripple of 1-bit cells, with registered result copy.
// Optional saturating borrow-event counter enabled by FULLSUB_BORROW_CNT_EN.

module full_subtractor_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_br,
  output logic o_d,
  output logic o_br
);
  assign o_d  = i_a ^ i_b ^ i_br;
  assign o_br = (~i_a & i_b) | (~(i_a ^ i_b) & i_br);
endmodule

module full_subtractor_behav #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [WIDTH-1:0] diff_q,
  output logic             borrow_out_q,
  output logic [CNT_W-1:0] borrow_cnt
);
  logic [WIDTH:0]   w_br;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] r_diff_q;
  logic             r_borrow_q;

  assign w_br[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .i_a  (a[i]),
      .i_b  (b[i]),
      .i_br (w_br[i]),
      .o_d  (w_diff[i]),
      .o_br (w_br[i+1])
    );
  end

  assign diff       = w_diff;
  assign borrow_out = w_br[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff_q   <= '0;
      r_borrow_q <= 1'b0;
    end else begin
      r_diff_q   <= w_diff;
      r_borrow_q <= w_br[WIDTH];
    end
  end

  assign diff_q       = r_diff_q;
  assign borrow_out_q = r_borrow_q;

`ifdef FULLSUB_BORROW_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_br[WIDTH] && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign borrow_cnt = r_cnt;
`else
  assign borrow_cnt = '0;
`endif

endmodule

// File: tb/tb_full_subtractor_behav.sv
// Scoreboard bench for full_subtractor_behav: WIDTH=1 (CNT_W=2) and WIDTH=4 instances.
module tb_full_subtractor_behav;
  logic       clk, rst_n;
  logic       a1, b1, bi1, d1, bo1, dq1, bq1;
  logic [1:0] cnt1;
  logic [3:0] a4, b4, d4, dq4;
  logic       bi4, bo4, bq4;
  logic [7:0] cnt4;

  int errs = 0;
  int checks = 0;
  int sb[$];

  full_subtractor_behav #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .borrow_in(bi1),
    .diff(d1), .borrow_out(bo1), .diff_q(dq1), .borrow_out_q(bq1), .borrow_cnt(cnt1)
  );

  full_subtractor_behav #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .borrow_in(bi4),
    .diff(d4), .borrow_out(bo4), .diff_q(dq4), .borrow_out_q(bq4), .borrow_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model(input int a, input int b, input int bi, input int w);
    return (a - b - bi) & ((1 << (w + 1)) - 1);
  endfunction

  initial begin
    int ta[6] = '{3, 9, 0, 15, 0, 8};
    int tb[6] = '{5, 4, 15, 0, 0, 8};
    int tc[6] = '{0, 1, 1, 0, 1, 0};
    int ecnt;

    rst_n = 1'b0;
    a1 = 0; b1 = 0; bi1 = 0;
    a4 = 0; b4 = 0; bi4 = 0;
    #1;
    chk("rst_dq1", 32'(dq1), 0);
    chk("rst_bq1", 32'(bq1), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    chk("rst_dq4", 32'(dq4), 0);
    chk("rst_bq4", 32'(bq4), 0);
    chk("rst_cnt4", 32'(cnt4), 0);

    // WIDTH=1 truth table, combinational, while reset is still held
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; bi1 = i[0];
      sb.push_back(model(i >> 2 & 1, i >> 1 & 1, i & 1, 1));
      #10;
      chk($sformatf("tt%0d", i), 32'({bo1, d1}), sb.pop_front());
    end

    // WIDTH=4 directed and boundary cases
    for (int i = 0; i < 6; i++) begin
      a4 = 4'(ta[i]); b4 = 4'(tb[i]); bi4 = tc[i][0];
      sb.push_back(model(ta[i], tb[i], tc[i], 4));
      #10;
      chk($sformatf("w4_dir%0d", i), 32'({bo4, d4}), sb.pop_front());
    end

    // WIDTH=4 random combinational
    for (int i = 0; i < 16; i++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(0, 15)); rb = int'($urandom_range(0, 15)); rc = int'($urandom_range(0, 1));
      a4 = 4'(ra); b4 = 4'(rb); bi4 = rc[0];
      sb.push_back(model(ra, rb, rc, 4));
      #3;
      chk("w4_rnd", 32'({bo4, d4}), sb.pop_front());
    end

    // Registered latency
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 0; b1 = 0; bi1 = 0;
    @(posedge clk); #1;
    a1 = 0; b1 = 1; bi1 = 0;
    sb.push_back(model(0, 1, 0, 1));
    chk("lat_pre", 32'({bq1, dq1}), 0);
    @(posedge clk); #1;
    chk("lat_post", 32'({bq1, dq1}), sb.pop_front());

    // Async reset between edges with nonzero registers
    @(negedge clk); #2;
    rst_n = 1'b0;
    sb.push_back(model(0, 1, 0, 1));
    #1;
    chk("arst_dq1", 32'(dq1), 0);
    chk("arst_bq1", 32'(bq1), 0);
    chk("arst_cnt1", 32'(cnt1), 0);
    chk("arst_comb", 32'({bo1, d1}), sb.pop_front());

    // Counter saturation with a=0,b=1 held
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
`ifdef FULLSUB_BORROW_CNT_EN
      ecnt = (k > 3) ? 3 : k;
`else
      ecnt = 0;
`endif
      sb.push_back(ecnt);
      @(posedge clk); #1;
      chk($sformatf("cnt_e%0d", k), 32'(cnt1), sb.pop_front());
      chk("cnt_bq", 32'(bq1), 1);
    end

    // WIDTH=4 random registered path
    for (int i = 0; i < 12; i++) begin
      int ra, rb, rc;
      @(negedge clk);
      ra = int'($urandom_range(0, 15)); rb = int'($urandom_range(0, 15)); rc = int'($urandom_range(0, 1));
      a4 = 4'(ra); b4 = 4'(rb); bi4 = rc[0];
      sb.push_back(model(ra, rb, rc, 4));
      @(posedge clk); #1;
      chk("w4_reg", 32'({bq4, dq4}), sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
